mem_arbiter: RTL and testbench
==============================

Name: mem_arbiter

Overview:
- Shares one BRAM memory port (68-bit request/response, put/get valid-ready) between NUM_CLIENTS requesters, e.g. instruction fetch and load/store.
- Issues requests under round-robin priority.
- Records each issuing client's ID in an in-order tag FIFO and routes each memory response back to that client.
- Sits between the core's memory interfaces and the memory model wrapper.

Parameters:
- NUM_CLIENTS, 2, number of requesters; legal values 2..4.
- MAX_OUTSTANDING, 4, tag FIFO depth (max requests issued but not yet answered); power of two, at least 2.
- REQ_W, 68, request/response payload width: {byte_en[3:0], addr[31:0], data[31:0]}.

Ports:
- CLK  in  1  clock.
- RST_N  in  1  asynchronous active-low reset.
- cli_req_valid  in  NUM_CLIENTS  per-client request valid.
- cli_req_data  in  NUM_CLIENTS*REQ_W  per-client request payload; client i occupies bits [i*REQ_W +: REQ_W].
- cli_req_ready  out  NUM_CLIENTS  per-client request accepted.
- cli_resp_valid  out  NUM_CLIENTS  per-client response valid.
- cli_resp_data  out  REQ_W  response payload, shared by all clients.
- cli_resp_ready  in  NUM_CLIENTS  per-client response accept.
- put_valid  out  1  request to memory.
- put_request  out  REQ_W  request payload to memory.
- put_ready  in  1  memory accepts request.
- get_valid  out  1  arbiter dequeues memory response.
- get_ready  in  1  memory response available.
- get_response  in  REQ_W  memory response payload.
- outstanding  out  $clog2(MAX_OUTSTANDING)+1  current tag FIFO occupancy.
- err_spurious  out  1  sticky flag: memory presented a response while no request was outstanding.

Behaviour:
- Reset (RST_N low, async): tag FIFO emptied, rr_ptr=0, err_spurious=0. Outputs while in reset: put_valid=0, get_valid=0, cli_req_ready=0, cli_resp_valid=0, outstanding=0.
- Reset asserted mid-transaction drops all in-flight tags. Responses for those tags that arrive after reset set err_spurious.
- Arbitration is combinational:
  - Candidates: clients with cli_req_valid=1.
  - Grant goes to the first candidate at or after rr_ptr, scanning upward with wrap-around.
  - put_valid = (any candidate) && !fifo_full.
  - put_request = cli_req_data of the granted client.
  - cli_req_ready[g] = put_ready && !fifo_full for granted client g; 0 for all other clients.
- Issue fires on put_valid && put_ready:
  - Push g into the tag FIFO.
  - rr_ptr <= (g+1) mod NUM_CLIENTS. rr_ptr is unchanged on cycles with no issue.
- Clients hold cli_req_valid and cli_req_data stable until ready. The arbiter may re-grant differently only if no issue occurred.
- Response routing is combinational:
  - h = tag FIFO head.
  - cli_resp_valid[h] = get_ready && !fifo_empty; 0 for all others.
  - cli_resp_data = get_response.
  - get_valid = !fifo_empty && cli_resp_ready[h].
  - On get_valid && get_ready: pop the FIFO.
- Responses return in issue order. No reordering, no tag bits sent to memory.
- fifo_full blocks issue even if a pop happens in the same cycle: push is allowed only when not full at the cycle start.
- Push and pop in the same cycle with FIFO non-empty and not full: occupancy unchanged, head advances.
- Empty FIFO with get_ready=1:
  - get_valid stays 0 and no client sees a response.
  - err_spurious is set one cycle later and held until reset.
- Latency: zero added cycles on both paths (combinational pass-through). Memory latency is unchanged.
- outstanding is registered FIFO occupancy, range 0..MAX_OUTSTANDING. Pointers wrap modulo MAX_OUTSTANDING.

Decomposition:
- Package mem_arb_pkg holds:
  - REQ_W=68.
  - mem_req_t struct {byte_en[3:0], addr[31:0], data[31:0]}.
  - Client-ID type sized $clog2(NUM_CLIENTS).
- Sub-module tag_fifo (parameters DEPTH, W):
  - Ports: push, pop, din, dout, full, empty, count.
  - Async active-low reset.
  - Power-of-two circular buffer with an extra wrap bit on each pointer.

Test Plan:
1. Reset released, no requests, get_ready=0 -> all outputs 0, outstanding=0. Assert RST_N low mid-cycle -> outputs drop immediately, no clock edge required.
2. Client 0 only; write req {4'hF, 32'h100, 32'hDEADBEEF}; put_ready=1; memory responds 2 cycles later -> cli_req_ready[0]=1 in the issue cycle, outstanding 0→1→0, cli_resp_valid[0]=1 with that payload, cli_resp_valid[1]=0.
3. Both clients valid every cycle, put_ready=1, memory answers each request one cycle later -> grants alternate 0,1,0,1 for 8 issues; responses routed 0,1,0,1; no starvation.
4. put_ready=1, get_ready=0, both clients streaming -> 4 issues, then outstanding=4 and put_valid=0. Assert get_ready with cli_resp_ready=1 -> one pop per cycle. Issue resumes the cycle after the first pop.
5. Head client 1 holds cli_resp_ready[1]=0 while get_ready=1 -> get_valid=0 and the FIFO does not pop. Release ready -> delivered to client 1 in one cycle.
6. get_ready=1 with empty FIFO -> no client response, err_spurious=1 the next cycle, held until RST_N=0.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared types for the memory-port arbiter: request payload layout, client-ID
// type and the round-robin selection helper.
package mem_arb_pkg;

  localparam int REQ_W       = 68;
  // The client-ID type is sized for the largest legal client count (4). Smaller
  // configurations leave the upper ID bits at zero.
  localparam int MAX_CLIENTS = 4;
  localparam int CLIENT_ID_W = $clog2(MAX_CLIENTS);

  typedef struct packed {
    logic [3:0]  byte_en;
    logic [31:0] addr;
    logic [31:0] data;
  } mem_req_t;

  typedef logic [CLIENT_ID_W-1:0] client_id_t;

  // Returns the first requesting client at or after ptr, wrapping within n
  // clients. Returns ptr when nobody requests. The loop runs from the farthest
  // offset down, so the nearest requester is the last one written and wins.
  function automatic client_id_t rr_pick(input logic [MAX_CLIENTS-1:0] valid,
                                         input client_id_t            ptr,
                                         input int                    n);
    client_id_t pick;
    int         idx;
    pick = ptr;
    for (int k = MAX_CLIENTS - 1; k >= 0; k--) begin
      if (k < n) begin
        idx = (int'(ptr) + k) % n;
        if (valid[idx]) pick = client_id_t'(idx);
      end
    end
    return pick;
  endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// Bus bundle around the arbiter. The client-facing request/response channels
// and the memory-facing put/get channels share one interface. The slave
// modport is the arbiter's view. The master modport is the surrounding system's
// view: the clients plus the memory model wrapper.
interface mem_arbiter_if #(
  parameter int NUM_CLIENTS = 2
);
  import mem_arb_pkg::*;

  logic [NUM_CLIENTS-1:0]       cli_req_valid;
  logic [NUM_CLIENTS*REQ_W-1:0] cli_req_data;
  logic [NUM_CLIENTS-1:0]       cli_req_ready;
  logic [NUM_CLIENTS-1:0]       cli_resp_valid;
  mem_req_t                     cli_resp_data;
  logic [NUM_CLIENTS-1:0]       cli_resp_ready;

  logic                         put_valid;
  mem_req_t                     put_request;
  logic                         put_ready;
  logic                         get_valid;
  logic                         get_ready;
  mem_req_t                     get_response;

  modport slave (
    input  cli_req_valid, cli_req_data, cli_resp_ready, put_ready,
           get_ready, get_response,
    output cli_req_ready, cli_resp_valid, cli_resp_data, put_valid,
           put_request, get_valid
  );

  modport master (
    output cli_req_valid, cli_req_data, cli_resp_ready, put_ready,
           get_ready, get_response,
    input  cli_req_ready, cli_resp_valid, cli_resp_data, put_valid,
           put_request, get_valid
  );

endinterface

// File: rtl/mem_arbiter_tag_fifo.sv
// In-order tag FIFO. It holds the ID of each client whose request went to
// memory and is still waiting for its response. It is a power-of-two circular
// buffer. Each pointer carries one extra wrap bit, so full and empty can be
// told apart without a separate counter.
module tag_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic                     pop,
  input  logic [W-1:0]             din,
  output logic [W-1:0]             dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0] mem [DEPTH];
  logic [AW:0]  wr_ptr;
  logic [AW:0]  rd_ptr;
  logic         do_push;
  logic         do_pop;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign count   = wr_ptr - rd_ptr;
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem[rd_ptr[AW-1:0]];

  // Pointer update. Both pointers wrap naturally through the extra MSB.
  // NOTE: registered state uses non-blocking assignments, so every always_ff
  // reads pre-edge values regardless of evaluation order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Tag storage write.
  // NOTE: the array is deliberately not reset. The pointers alone decide which
  // entries are live, so stale contents are never observed.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= din;
  end

endmodule

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one BRAM put/get port between NUM_CLIENTS
// requesters. Each issued request pushes its client ID into an in-order tag
// FIFO. Memory responses come back in issue order and are steered to the
// client at the FIFO head. Both paths are combinational pass-through, so the
// arbiter adds no cycles of latency.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int NUM_CLIENTS     = 2,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic                               CLK,
  input  logic                               RST_N,
  mem_arbiter_if.slave                       bus,
  output logic [$clog2(MAX_OUTSTANDING):0]   outstanding,
  output logic                               err_spurious
);

  logic [MAX_CLIENTS-1:0] req_valid_ext;
  client_id_t             rr_ptr;
  client_id_t             rr_ptr_next;
  client_id_t             grant;
  client_id_t             head;
  logic                   any_req;
  logic                   fifo_full;
  logic                   fifo_empty;
  logic                   head_ready;
  logic                   issue;
  logic                   retire;

  // Request side: pick the round-robin winner and drive the put channel.
  // The put channel is gated with RST_N so it stays quiet while reset is held.
  // NOTE: every combinational output gets a default before any conditional
  // assignment, so no path through the block can infer a latch.
  always_comb begin
    req_valid_ext                  = '0;
    req_valid_ext[NUM_CLIENTS-1:0] = bus.cli_req_valid;
    any_req                        = |bus.cli_req_valid;
    grant                          = rr_pick(req_valid_ext, rr_ptr, NUM_CLIENTS);
    bus.put_valid                  = RST_N && any_req && !fifo_full;
    issue                          = bus.put_valid && bus.put_ready;
    bus.put_request                = '0;
    bus.cli_req_ready              = '0;
    for (int i = 0; i < NUM_CLIENTS; i++) begin
      if (grant == client_id_t'(i)) begin
        bus.put_request      = bus.cli_req_data[i*REQ_W +: REQ_W];
        bus.cli_req_ready[i] = bus.put_valid && bus.put_ready;
      end
    end
    rr_ptr_next = (grant == client_id_t'(NUM_CLIENTS - 1)) ? '0 : grant + 1'b1;
  end

  // Response side: steer the memory response to the client recorded at the
  // FIFO head. Memory is dequeued only when that client can take the response.
  always_comb begin
    head_ready         = 1'b0;
    bus.cli_resp_valid = '0;
    for (int i = 0; i < NUM_CLIENTS; i++) begin
      if (head == client_id_t'(i)) begin
        head_ready            = bus.cli_resp_ready[i];
        bus.cli_resp_valid[i] = RST_N && bus.get_ready && !fifo_empty;
      end
    end
    bus.cli_resp_data = bus.get_response;
    bus.get_valid     = RST_N && !fifo_empty && head_ready;
    retire            = bus.get_valid && bus.get_ready;
  end

  // Round-robin pointer: moves past the client just issued, holds otherwise.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N)      rr_ptr <= '0;
    else if (issue)  rr_ptr <= rr_ptr_next;
  end

  // Sticky error: memory offered a response with nothing outstanding.
  // This includes responses to tags that a reset has already dropped.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N)                              err_spurious <= 1'b0;
    else if (bus.get_ready && fifo_empty)    err_spurious <= 1'b1;
  end

  tag_fifo #(
    .DEPTH (MAX_OUTSTANDING),
    .W     (CLIENT_ID_W)
  ) u_tags (
    .clk   (CLK),
    .rst_n (RST_N),
    .push  (issue),
    .pop   (retire),
    .din   (grant),
    .dout  (head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (outstanding)
  );

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter. The reference model is a queue of issued
// {client, request} records. It also serves as the memory's in-order request
// log. Round-robin is recomputed arithmetically from a plain integer pointer.
module tb_mem_arbiter;
  import mem_arb_pkg::*;

  localparam int N  = 2;
  localparam int MO = 4;

  logic                    CLK = 1'b0;
  logic                    RST_N = 1'b0;
  logic [$clog2(MO):0]     outstanding;
  logic                    err_spurious;

  mem_arbiter_if #(.NUM_CLIENTS(N)) bus();

  mem_arbiter #(
    .NUM_CLIENTS     (N),
    .MAX_OUTSTANDING (MO)
  ) dut (
    .CLK          (CLK),
    .RST_N        (RST_N),
    .bus          (bus.slave),
    .outstanding  (outstanding),
    .err_spurious (err_spurious)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    int       cli;
    mem_req_t req;
    int       t;
  } rec_t;

  rec_t      q[$];
  int        rr;
  bit        err;
  int        cyc;
  logic [N-1:0] pend;
  logic [N-1:0] stream;
  logic [N-1:0] crr_val;
  mem_req_t  cdata[N];
  bit        pr_val, pr_rand, resp_rand, rand_req, mem_hold, mem_rand, spur;
  int        mem_lat;
  int        dut_g[$];
  int        dut_r[$];
  int        n_tests;
  int        n_fail;
  mem_req_t  t2_req;

  function automatic mem_req_t new_req();
    mem_req_t r;
    r.byte_en = 4'($urandom_range(0, 15));
    r.addr    = $urandom;
    r.data    = $urandom;
    return r;
  endfunction

  // Memory's response to a request: recognisably derived from it.
  function automatic mem_req_t mem_xform(input mem_req_t r);
    mem_req_t o;
    o      = r;
    o.data = ~r.data;
    o.addr = r.addr + 32'h4;
    return o;
  endfunction

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] expv);
    n_tests++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Drive inputs for this cycle (called 1 ns after the rising edge).
  task automatic drive();
    logic [N-1:0] rmask;
    for (int i = 0; i < N; i++) begin
      if (!pend[i] && (stream[i] || (rand_req && $urandom_range(0, 2) == 0))) begin
        pend[i]  = 1'b1;
        cdata[i] = new_req();
      end
      bus.cli_req_data[i*REQ_W +: REQ_W] = cdata[i];
    end
    bus.cli_req_valid = pend;
    bus.put_ready     = pr_rand ? ($urandom_range(0, 1) == 1) : pr_val;
    rmask             = $urandom_range(0, (1 << N) - 1);
    bus.cli_resp_ready = resp_rand ? rmask : crr_val;
    if (spur) begin
      bus.get_ready    = 1'b1;
      bus.get_response = new_req();
    end else if (!mem_hold && q.size() > 0 && (cyc - q[0].t) >= mem_lat &&
                 (!mem_rand || $urandom_range(0, 1) == 1)) begin
      bus.get_ready    = 1'b1;
      bus.get_response = mem_xform(q[0].req);
    end else begin
      bus.get_ready    = 1'b0;
      bus.get_response = new_req();
    end
    #2;
  endtask

  // Compare every output with the model, then advance across the clock edge.
  task automatic step();
    int sz, g, h;
    bit full, empty, any, e_pv, e_gv, fire_i, fire_p, spur_ev;
    logic [N-1:0] e_rdy, e_rv;
    sz    = q.size();
    full  = (sz == MO);
    empty = (sz == 0);
    any   = (pend != '0);
    g     = 0;
    for (int k = N - 1; k >= 0; k--)
      if (pend[(rr + k) % N]) g = (rr + k) % N;
    e_pv  = any && !full;
    e_rdy = '0;
    if (e_pv && bus.put_ready) e_rdy[g] = 1'b1;
    h     = empty ? 0 : q[0].cli;
    e_rv  = '0;
    if (!empty && bus.get_ready) e_rv[h] = 1'b1;
    e_gv  = !empty && bus.cli_resp_ready[h];

    check("put_valid", bus.put_valid, e_pv);
    check("cli_req_ready", bus.cli_req_ready, e_rdy);
    if (e_pv) check("put_request", bus.put_request, cdata[g]);
    check("cli_resp_valid", bus.cli_resp_valid, e_rv);
    check("get_valid", bus.get_valid, e_gv);
    if (e_rv != '0) check("cli_resp_data", bus.cli_resp_data, mem_xform(q[0].req));
    check("outstanding", outstanding, sz);
    check("err_spurious", err_spurious, err);

    if (bus.put_valid && bus.put_ready)
      for (int i = 0; i < N; i++) if (bus.cli_req_ready[i]) dut_g.push_back(i);
    if (bus.get_valid && bus.get_ready)
      for (int i = 0; i < N; i++) if (bus.cli_resp_valid[i]) dut_r.push_back(i);

    fire_i  = e_pv && bus.put_ready;
    fire_p  = e_gv && bus.get_ready;
    spur_ev = bus.get_ready && empty;

    @(posedge CLK);
    if (fire_p) void'(q.pop_front());
    if (fire_i) begin
      rec_t r;
      r.cli = g;
      r.req = cdata[g];
      r.t   = cyc;
      q.push_back(r);
      rr      = (g + 1) % N;
      pend[g] = 1'b0;
    end
    if (spur_ev) err = 1'b1;
    cyc++;
    #1;
  endtask

  task automatic cycle();
    drive();
    step();
  endtask

  task automatic run(input int n);
    for (int k = 0; k < n; k++) cycle();
  endtask

  // Assert reset mid-cycle (no clock edge) and check that outputs drop at once.
  task automatic do_reset_now();
    RST_N = 1'b0;
    #1;
    check("rst_put_valid", bus.put_valid, 1'b0);
    check("rst_cli_req_ready", bus.cli_req_ready, '0);
    check("rst_get_valid", bus.get_valid, 1'b0);
    check("rst_cli_resp_valid", bus.cli_resp_valid, '0);
    check("rst_outstanding", outstanding, 0);
    check("rst_err_spurious", err_spurious, 1'b0);
    q.delete();
    rr  = 0;
    err = 1'b0;
    @(posedge CLK);
    cyc++;
    #1;
    RST_N = 1'b1;
  endtask

  task automatic drain(input string tag);
    stream = '0; rand_req = 0; pr_rand = 0; pr_val = 1; resp_rand = 0;
    crr_val = '1; mem_hold = 0; mem_rand = 0; spur = 0;
    for (int k = 0; k < 60 && (q.size() != 0 || pend != '0); k++) cycle();
    check({tag, "_drained"}, outstanding, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    n_tests = 0; n_fail = 0; cyc = 0; rr = 0; err = 1'b0;
    pend = '0; stream = '0; crr_val = '1;
    pr_val = 0; pr_rand = 0; resp_rand = 0; rand_req = 0;
    mem_hold = 0; mem_rand = 0; spur = 0; mem_lat = 0;
    for (int i = 0; i < N; i++) cdata[i] = '0;
    bus.cli_req_valid = '0; bus.cli_req_data = '0; bus.cli_resp_ready = '0;
    bus.put_ready = 1'b0; bus.get_ready = 1'b0; bus.get_response = '0;
    repeat (2) @(posedge CLK);
    #1;
    RST_N = 1'b1;

    // Step 1: idle after reset, then a mid-cycle reset while a client is granted.
    run(3);
    pend[0] = 1'b1; cdata[0] = new_req(); pr_val = 1;
    drive();
    check("t1_pre_ready", bus.cli_req_ready, 2'b01);
    check("t1_pre_put_valid", bus.put_valid, 1'b1);
    do_reset_now();
    drain("t1");

    // Step 2: single write from client 0, memory answers two cycles later.
    mem_lat = 2; crr_val = '1; pr_val = 1;
    t2_req  = '{byte_en: 4'hF, addr: 32'h100, data: 32'hDEADBEEF};
    pend[0] = 1'b1; cdata[0] = t2_req;
    drive();
    check("t2_req_ready", bus.cli_req_ready, 2'b01);
    check("t2_put_request", bus.put_request, t2_req);
    step();
    check("t2_out_1", outstanding, 1);
    drive();
    check("t2_no_resp_yet", bus.cli_resp_valid, 2'b00);
    step();
    check("t2_out_still_1", outstanding, 1);
    drive();
    check("t2_resp_valid", bus.cli_resp_valid, 2'b01);
    check("t2_resp_data", bus.cli_resp_data, mem_xform(t2_req));
    step();
    check("t2_out_0", outstanding, 0);

    // Step 3: both clients streaming, one-cycle memory; grants alternate.
    drive();
    do_reset_now();
    stream = '1; mem_lat = 1; dut_g.delete(); dut_r.delete();
    for (int k = 0; k < 40 && dut_g.size() < 8; k++) cycle();
    drain("t3");
    check("t3_grant_count", dut_g.size() >= 8, 1'b1);
    for (int k = 0; k < 8 && k < dut_g.size(); k++)
      check($sformatf("t3_grant%0d", k), dut_g[k], k % 2);
    for (int k = 0; k < 8 && k < dut_r.size(); k++)
      check($sformatf("t3_resp%0d", k), dut_r[k], k % 2);

    // Step 4: fill the tag FIFO, then drain one per cycle; issue resumes after first pop.
    stream = '1; mem_hold = 1; pr_val = 1;
    run(4);
    drive();
    check("t4_full_put_valid", bus.put_valid, 1'b0);
    check("t4_full_outstanding", outstanding, 4);
    step();
    mem_hold = 0; mem_lat = 0;
    drive();
    check("t4_pop_blocks_issue", bus.put_valid, 1'b0);
    check("t4_pop_get_valid", bus.get_valid, 1'b1);
    step();
    drive();
    check("t4_resume_put_valid", bus.put_valid, 1'b1);
    check("t4_resume_outstanding", outstanding, 3);
    step();
    drain("t4");

    // Step 5: head client 1 stalls its response ready.
    pend[1] = 1'b1; cdata[1] = new_req(); mem_hold = 1;
    cycle();
    mem_hold = 0; mem_lat = 0; crr_val = 2'b01;
    for (int k = 0; k < 2; k++) begin
      drive();
      check("t5_stall_get_valid", bus.get_valid, 1'b0);
      check("t5_stall_resp_valid", bus.cli_resp_valid, 2'b10);
      step();
      check("t5_stall_outstanding", outstanding, 1);
    end
    crr_val = '1;
    drive();
    check("t5_release_get_valid", bus.get_valid, 1'b1);
    check("t5_release_resp_valid", bus.cli_resp_valid, 2'b10);
    step();
    check("t5_release_outstanding", outstanding, 0);

    // Step 6: response offered with nothing outstanding -> sticky error.
    spur = 1;
    drive();
    check("t6_resp_valid", bus.cli_resp_valid, 2'b00);
    check("t6_get_valid", bus.get_valid, 1'b0);
    check("t6_err_before", err_spurious, 1'b0);
    step();
    spur = 0;
    check("t6_err_set", err_spurious, 1'b1);
    run(3);
    check("t6_err_held", err_spurious, 1'b1);
    drive();
    do_reset_now();

    // Step 7: reset with tags in flight; a late response then flags an error.
    mem_hold = 1;
    pend[0] = 1'b1; cdata[0] = new_req();
    cycle();
    pend[0] = 1'b1; cdata[0] = new_req();
    cycle();
    check("t7_outstanding", outstanding, 2);
    mem_hold = 0; mem_lat = 0; crr_val = '0;
    drive();
    check("t7_pre_resp_valid", bus.cli_resp_valid, 2'b01);
    do_reset_now();
    crr_val = '1; spur = 1;
    drive();
    check("t7_late_resp_valid", bus.cli_resp_valid, 2'b00);
    step();
    spur = 0;
    check("t7_err_set", err_spurious, 1'b1);
    drive();
    do_reset_now();

    // Step 8: randomized traffic against the model, with one reset midway.
    rand_req = 1; pr_rand = 1; resp_rand = 1; mem_rand = 1;
    for (int k = 0; k < 400; k++) begin
      if (k % 50 == 0) mem_lat = $urandom_range(0, 2);
      if (k == 200) begin
        drive();
        do_reset_now();
      end else begin
        cycle();
      end
    end
    drain("t8");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
